// File: rtl/wireframe_edge_writer.sv
// Wireframe SRAM writer: clears the rows a triangle spans, then draws its
// three edges with Bresenham, one SRAM write per cycle.
module wireframe_edge_writer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] y0,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] y2,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic               sram_wdata,
    output logic               sram_we
);
    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic signed [16:0] Y_LAST = 17'(HEIGHT - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_CLEAR, S_SETUP, S_DRAW, S_DONE} state_t;

    state_t              state_q, state_d;
    logic signed [15:0]  vx_q [3], vx_d [3];
    logic signed [15:0]  vy_q [3], vy_d [3];
    logic [YW-1:0]       ymax_q, ymax_d, cy_q, cy_d;
    logic [XW-1:0]       cx_q, cx_d;
    logic [1:0]          edge_q, edge_d;
    logic signed [15:0]  xe_q, xe_d, ye_q, ye_d, px_q, px_d, py_q, py_d;
    logic signed [16:0]  dx_q, dx_d, dy_q, dy_d;
    logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [17:0]  err_q, err_d;
    logic                busy_q, busy_d, done_q, done_d, we_q, we_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic signed [15:0]  ylo, yhi, xs_s, ys_s, xe_s, ye_s;
    logic signed [16:0]  ymin_c, ymax_c, ddx, ddy, dx_abs, dy_neg;
    logic signed [18:0]  e2;
    logic                step_x, step_y, at_end, px_in, py_in;

    // Clipped vertical extent of the latched triangle.
    always_comb begin
        ylo = vy_q[0];
        yhi = vy_q[0];
        for (int i = 1; i < 3; i++) begin
            if (vy_q[i] < ylo) ylo = vy_q[i];
            if (vy_q[i] > yhi) yhi = vy_q[i];
        end
        ymin_c = ylo[15] ? 17'sd0 : $signed({ylo[15], ylo});
        ymax_c = ($signed({yhi[15], yhi}) > Y_LAST) ? Y_LAST : $signed({yhi[15], yhi});
    end

    // Endpoints and deltas of the edge selected by edge_q.
    always_comb begin
        xs_s = vx_q[2];
        ys_s = vy_q[2];
        xe_s = vx_q[0];
        ye_s = vy_q[0];
        case (edge_q)
            2'd0: begin xs_s = vx_q[0]; ys_s = vy_q[0]; xe_s = vx_q[1]; ye_s = vy_q[1]; end
            2'd1: begin xs_s = vx_q[1]; ys_s = vy_q[1]; xe_s = vx_q[2]; ye_s = vy_q[2]; end
            default: ;
        endcase
        ddx    = $signed({xe_s[15], xe_s}) - $signed({xs_s[15], xs_s});
        ddy    = $signed({ye_s[15], ye_s}) - $signed({ys_s[15], ys_s});
        dx_abs = ddx[16] ? -ddx : ddx;
        dy_neg = ddy[16] ? ddy : -ddy;
    end

    // Bresenham step decision from the current (old) error term.
    always_comb begin
        e2     = $signed({err_q, 1'b0});
        step_x = (e2 >= $signed({{2{dy_q[16]}}, dy_q}));
        step_y = (e2 <= $signed({{2{dx_q[16]}}, dx_q}));
        at_end = (px_q == xe_q) && (py_q == ye_q);
    end

    // State and datapath registers, including the registered SRAM port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            vx_q     <= '{default: '0};
            vy_q     <= '{default: '0};
            ymax_q   <= '0;
            cy_q     <= '0;
            cx_q     <= '0;
            edge_q   <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            px_q     <= '0;
            py_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            ymax_q   <= ymax_d;
            cy_q     <= cy_d;
            cx_q     <= cx_d;
            edge_q   <= edge_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            px_q     <= px_d;
            py_q     <= py_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d  = state_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        ymax_d   = ymax_q;
        cy_d     = cy_q;
        cx_d     = cx_q;
        edge_d   = edge_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        px_d     = px_q;
        py_d     = py_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vx_d[0] = x0; vx_d[1] = x1; vx_d[2] = x2;
                    vy_d[0] = y0; vy_d[1] = y1; vy_d[2] = y2;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (ymin_c > ymax_c) begin
                    edge_d  = 2'd0;
                    state_d = S_SETUP;
                end else begin
                    cy_d    = YW'(ymin_c);
                    ymax_d  = YW'(ymax_c);
                    cx_d    = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cx_q == XW'(WIDTH - 1)) begin
                    cx_d = '0;
                    if (cy_q == ymax_q) begin
                        edge_d  = 2'd0;
                        state_d = S_SETUP;
                    end else begin
                        cy_d = cy_q + YW'(1);
                    end
                end else begin
                    cx_d = cx_q + XW'(1);
                end
            end
            S_SETUP: begin
                px_d     = xs_s;
                py_d     = ys_s;
                xe_d     = xe_s;
                ye_d     = ye_s;
                dx_d     = dx_abs;
                dy_d     = dy_neg;
                sx_neg_d = !(xs_s < xe_s);
                sy_neg_d = !(ys_s < ye_s);
                err_d    = $signed({dx_abs[16], dx_abs}) + $signed({dy_neg[16], dy_neg});
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (at_end) begin
                    if (edge_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        edge_d  = edge_q + 2'd1;
                        state_d = S_SETUP;
                    end
                end else begin
                    err_d = err_q
                          + (step_x ? $signed({dy_q[16], dy_q}) : 18'sd0)
                          + (step_y ? $signed({dx_q[16], dx_q}) : 18'sd0);
                    if (step_x) px_d = sx_neg_q ? px_q - 16'sd1 : px_q + 16'sd1;
                    if (step_y) py_d = sy_neg_q ? py_q - 16'sd1 : py_q + 16'sd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs for the state being entered, so each write lands in its own state's cycle.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        wdata_d = 1'b0;
        addr_d  = '0;
        px_in   = !px_d[15] && ({16'd0, px_d} < 32'(WIDTH));
        py_in   = !py_d[15] && ({16'd0, py_d} < 32'(HEIGHT));
        case (state_d)
            S_IDLE: ;
            S_CLEAR: begin
                busy_d = 1'b1;
                we_d   = 1'b1;
                addr_d = ADDR_W'(cy_d) * ADDR_W'(WIDTH) + ADDR_W'(cx_d);
            end
            S_DRAW: begin
                busy_d  = 1'b1;
                wdata_d = 1'b1;
                if (px_in && py_in) begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(py_d[YW-1:0]) * ADDR_W'(WIDTH) + ADDR_W'(px_d[XW-1:0]);
                end
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: busy_d = 1'b1;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sram_we    = we_q;
    assign sram_wdata = wdata_q;
    assign sram_addr  = addr_q;

endmodule

// File: tb/tb_wireframe_edge_writer.sv
// Scoreboard bench: a behavioural model pushes the expected per-cycle SRAM
// port trace for each accepted triangle; a negedge monitor pops and compares.
module tb_wireframe_edge_writer;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic busy, done, sram_wdata, sram_we;
    logic [AW-1:0] sram_addr;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          we;
        logic          wcare;
        logic          wd;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   drw_log[$];
    int   clr_log[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   last_len = 0;

    int t1_draw[$] = '{18, 19, 20, 21, 22, 22, 37, 52, 67, 82, 82, 66, 50, 34, 18};
    int t2_draw[$] = '{0, 16, 33, 49, 66, 82, 82, 66, 49, 33, 16, 0, 0};
    int t3_draw[$] = '{0, 1, 2, 3, 3, 3, 2, 1, 0};

    wireframe_edge_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .busy(busy), .done(done), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_we(sram_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk_list(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_n"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) chk(tag, at(got, i), exp[i]);
    endtask

    task automatic push_e(input logic b, input logic d, input logic w, input logic c,
                          input logic wd, input int a);
        exp_t e;
        e.busy = b; e.done = d; e.we = w; e.wcare = c; e.wd = wd; e.addr = AW'(a);
        sb.push_back(e);
    endtask

    // Behavioural model of one triangle: one entry per cycle, INIT through DONE, then one idle cycle.
    task automatic push_trace(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int ax2, input int ay2, output int len);
        int vx[3];
        int vy[3];
        int lo, hi, xs, ys, xe, ye, dx, dy, sx, sy, err, e2, x, y;
        bit on, fin;
        vx[0] = ax0; vx[1] = ax1; vx[2] = ax2;
        vy[0] = ay0; vy[1] = ay1; vy[2] = ay2;
        len = 0;
        push_e(1, 0, 0, 0, 0, 0); len++;
        lo = vy[0]; hi = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vy[i] < lo) lo = vy[i];
            if (vy[i] > hi) hi = vy[i];
        end
        if (lo < 0) lo = 0;
        if (hi > H - 1) hi = H - 1;
        for (int r = lo; r <= hi; r++)
            for (int c = 0; c < W; c++) begin
                push_e(1, 0, 1, 1, 0, r * W + c); len++;
            end
        for (int k = 0; k < 3; k++) begin
            xs = vx[k]; ys = vy[k]; xe = vx[(k + 1) % 3]; ye = vy[(k + 1) % 3];
            push_e(1, 0, 0, 0, 0, 0); len++;
            dx = (xe > xs) ? xe - xs : xs - xe;
            dy = (ye > ys) ? ys - ye : ye - ys;
            sx = (xs < xe) ? 1 : -1;
            sy = (ys < ye) ? 1 : -1;
            err = dx + dy;
            x = xs; y = ys;
            fin = 0;
            while (!fin) begin
                on = (x >= 0) && (x < W) && (y >= 0) && (y < H);
                push_e(1, 0, on, 1, 1, on ? y * W + x : 0); len++;
                if (x == xe && y == ye) fin = 1;
                else begin
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; x += sx; end
                    if (e2 <= dx) begin err += dx; y += sy; end
                end
            end
        end
        push_e(1, 1, 0, 0, 0, 0); len++;
        push_e(0, 0, 0, 0, 0, 0);
    endtask

    // Drive start for one cycle (caller is inside an IDLE cycle), push the expectation on acceptance.
    task automatic accept(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int ax2, input int ay2);
        int len;
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1); x2 = 16'(ax2); y2 = 16'(ay2);
        start = 1'b1;
        @(posedge clk);
        push_trace(ax0, ay0, ax1, ay1, ax2, ay2, len);
        last_len = len;
        #1;
        start = 1'b0;
        x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom);
        y1 = 16'($urandom); x2 = 16'($urandom); y2 = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        sb.delete();
        #1;
    endtask

    // Monitor: log writes, count done pulses, compare each cycle with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] obs, expv;
        if (n_rst) begin
            if (sram_we) begin
                if (sram_wdata) drw_log.push_back(int'(sram_addr));
                else            clr_log.push_back(int'(sram_addr));
            end
            if (done) n_done++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                obs  = {21'd0, busy, done, sram_we, e.wcare ? sram_wdata : 1'b0,
                        sram_we ? sram_addr : AW'(0)};
                expv = {21'd0, e.busy, e.done, e.we, e.wcare ? e.wd : 1'b0, e.addr};
                chk("trace", obs, expv);
            end else begin
                chk("idle", {29'd0, busy, done, sram_we}, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nd;
        bit found;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {20'd0, busy, done, sram_we, sram_wdata, 1'b0, sram_addr}, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic triangle with exact done timing
        clr_log.delete(); drw_log.delete();
        accept(2, 1, 6, 1, 2, 5);
        k = 1; found = 0;
        while (k <= 400 && !found) begin
            @(negedge clk);
            if (done) found = 1;
            else k++;
        end
        chk("t1_done_cycle", k, 100);
        drain();
        chk("t1_clr_n", clr_log.size(), 80);
        chk("t1_clr_first", at(clr_log, 0), 16);
        chk("t1_clr_last", at(clr_log, 79), 95);
        chk_list("t1_draw", drw_log, t1_draw);

        // Steep edge retraced in reverse
        clr_log.delete(); drw_log.delete();
        accept(0, 0, 2, 5, 0, 0);
        drain();
        chk("t2_clr_n", clr_log.size(), 96);
        chk_list("t2_draw", drw_log, t2_draw);

        // Left-edge clipping
        clr_log.delete(); drw_log.delete();
        accept(-2, 0, 3, 0, 3, 0);
        drain();
        chk("t3_clr_n", clr_log.size(), 16);
        chk_list("t3_draw", drw_log, t3_draw);

        // Entirely above the screen
        clr_log.delete(); drw_log.delete();
        nd = n_done;
        accept(1, -5, 4, -5, 2, -5);
        drain();
        chk("t4_clr_n", clr_log.size(), 0);
        chk("t4_draw_n", drw_log.size(), 0);
        chk("t4_done_n", n_done - nd, 1);

        // Starts during CLEAR and DONE ignored; start right after DONE accepted
        nd = n_done;
        accept(2, 1, 6, 1, 2, 5);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (last_len - 4) @(posedge clk);
        #1;
        chk("t5_in_done", {31'd0, done}, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        accept(0, 0, 3, 2, 1, 4);
        drain();
        chk("t5_done_n", n_done - nd, 2);

        // Reset in the middle of CLEAR, then a clean rerun
        nd = n_done;
        accept(2, 1, 6, 1, 2, 5);
        repeat (10) @(posedge clk);
        #2;
        n_rst = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_mid", {29'd0, busy, done, sram_we}, 0);
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        clr_log.delete(); drw_log.delete();
        accept(2, 1, 6, 1, 2, 5);
        drain();
        chk("t6_clr_n", clr_log.size(), 80);
        chk_list("t6_draw", drw_log, t1_draw);
        chk("t6_done_n", n_done - nd, 1);

        // Random small triangles straddling the screen edges
        for (int t = 0; t < 6; t++) begin
            accept(int'($urandom_range(21)) - 3, int'($urandom_range(11)) - 2,
                   int'($urandom_range(21)) - 3, int'($urandom_range(11)) - 2,
                   int'($urandom_range(21)) - 3, int'($urandom_range(11)) - 2);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
